// File: rtl/ack_bus_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ack_bus_arbiter_rr                                         |
// | Description : Registered N-source ACK bus arbiter that holds the grant    |
// |               until the winner releases it, with round-robin or fixed    |
// |               priority. Also exports the resolved wired-AND debug bus.   |
// |               Optional macro ACK_ARB_TIMEOUT_EN adds a forced release    |
// |               after MAX_HOLD grant cycles.                                |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ack_bus_arbiter_rr #(
   parameter int N_SRC    = 4,
   parameter int ID_W     = $clog2(N_SRC),
   parameter int RR_MODE  = 1,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] req,
   output logic [N_SRC-1:0] ack_ready,
   output logic [ID_W-1:0]  winner_source_id,
   output logic             ack_event,
   output logic             busy,
   output logic             timeout_evt,
   output logic             ack_valid_n_bus_o,
   output logic [ID_W-1:0]  ack_id_bus_o
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [ID_W-1:0]  c_last_id = ID_W'(N_SRC - 1);
   localparam logic [ID_W:0]    c_n_src   = (ID_W + 1)'(N_SRC);

   generate
      if (N_SRC < 2) begin : g_bad_n_src
         $error("ack_bus_arbiter_rr: N_SRC must be at least 2");
      end
      if (MAX_HOLD < 2) begin : g_bad_max_hold
         $error("ack_bus_arbiter_rr: MAX_HOLD must be at least 2");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_SRC-1:0] r_ack_ready;
   logic [N_SRC-1:0] w_ready_nxt;
   logic [ID_W-1:0]  r_winner;
   logic [ID_W-1:0]  w_winner_nxt;
   logic             r_ack_event;
   logic             w_event_nxt;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [ID_W-1:0]  w_rr_ptr_nxt;

   logic             w_any_req;
   logic             w_found;
   logic [ID_W:0]    w_rr_idx;
   logic [ID_W-1:0]  w_sel_id;
   logic [ID_W-1:0]  w_id_and;

`ifdef ACK_ARB_TIMEOUT_EN
   localparam int               c_cnt_w     = $clog2(MAX_HOLD) + 1;
   localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(MAX_HOLD - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_sat   = {c_cnt_w{1'b1}};

   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic               r_timeout_evt;
   logic               w_timeout_nxt;
`endif

   assign w_any_req = |req;

   // Selection: round-robin scans from rr_ptr with wrap, fixed picks lowest ID
   always_comb begin
      w_sel_id = '0;
      w_found  = 1'b0;
      w_rr_idx = '0;
      if (RR_MODE != 0) begin
         for (int i = 0; i < N_SRC; i++) begin
            w_rr_idx = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
            if (w_rr_idx >= c_n_src) begin
               w_rr_idx = w_rr_idx - c_n_src;
            end
            if (!w_found && req[w_rr_idx[ID_W-1:0]]) begin
               w_found  = 1'b1;
               w_sel_id = w_rr_idx[ID_W-1:0];
            end
         end
      end else begin
         for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
               w_found  = 1'b1;
               w_sel_id = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ready_nxt  = r_ack_ready;
      w_winner_nxt = r_winner;
      w_event_nxt  = 1'b0;
      w_rr_ptr_nxt = r_rr_ptr;
`ifdef ACK_ARB_TIMEOUT_EN
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_any_req && w_found) begin
               w_state_nxt  = ST_GRANT;
               w_ready_nxt  = N_SRC'(1) << w_sel_id;
               w_winner_nxt = w_sel_id;
               w_event_nxt  = 1'b1;
               w_rr_ptr_nxt = (w_sel_id == c_last_id) ? '0 : w_sel_id + 1'b1;
`ifdef ACK_ARB_TIMEOUT_EN
               w_cnt_nxt    = '0;
`endif
            end
         end
         ST_GRANT: begin
            // A normal release wins over a timeout landing in the same cycle
            if (!req[r_winner]) begin
               w_state_nxt = ST_IDLE;
               w_ready_nxt = '0;
            end
`ifdef ACK_ARB_TIMEOUT_EN
            else if (r_cnt == c_hold_last) begin
               w_state_nxt   = ST_IDLE;
               w_ready_nxt   = '0;
               w_timeout_nxt = 1'b1;
            end else if (r_cnt != c_cnt_sat) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ack_ready <= '0;
         r_winner    <= '0;
         r_ack_event <= 1'b0;
         r_rr_ptr    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ack_ready <= w_ready_nxt;
         r_winner    <= w_winner_nxt;
         r_ack_event <= w_event_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
      end
   end

`ifdef ACK_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_timeout_evt <= 1'b0;
      end else begin
         r_cnt         <= w_cnt_nxt;
         r_timeout_evt <= w_timeout_nxt;
      end
   end

   assign timeout_evt = r_timeout_evt;
`else
   assign timeout_evt = 1'b0;
`endif

   // Model of the open-drain bus: each requester pulls low the zero bits of its ID
   always_comb begin
      w_id_and = '1;
      for (int i = 0; i < N_SRC; i++) begin
         if (req[i]) begin
            w_id_and = w_id_and & ID_W'(i);
         end
      end
   end

   assign ack_ready         = r_ack_ready;
   assign winner_source_id  = r_winner;
   assign ack_event         = r_ack_event;
   assign busy              = (r_state == ST_GRANT);
   assign ack_valid_n_bus_o = ~w_any_req;
   assign ack_id_bus_o      = w_id_and;

endmodule
`default_nettype wire

// File: tb/tb_ack_bus_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ack_bus_arbiter_rr                                      |
// | Description : Directed self-checking bench for ack_bus_arbiter_rr        |
// |               (round-robin, fixed-priority and short-hold instances).    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ack_bus_arbiter_rr;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [3:0] req = '0, req_fp = '0, req_to = '0;
   logic [3:0] ack_ready, ack_ready_fp, ack_ready_to;
   logic [1:0] winner, winner_fp, winner_to;
   logic       ack_event, ack_event_fp, ack_event_to;
   logic       busy, busy_fp, busy_to;
   logic       timeout_evt, timeout_fp, timeout_to;
   logic       valid_n, valid_n_fp, valid_n_to;
   logic [1:0] id_bus, id_bus_fp, id_bus_to;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ack_bus_arbiter_rr #(.N_SRC(4), .RR_MODE(1), .MAX_HOLD(16)) dut (
      .clk(clk), .rst(rst), .req(req), .ack_ready(ack_ready),
      .winner_source_id(winner), .ack_event(ack_event), .busy(busy),
      .timeout_evt(timeout_evt), .ack_valid_n_bus_o(valid_n), .ack_id_bus_o(id_bus)
   );

   ack_bus_arbiter_rr #(.N_SRC(4), .RR_MODE(0), .MAX_HOLD(16)) dut_fp (
      .clk(clk), .rst(rst), .req(req_fp), .ack_ready(ack_ready_fp),
      .winner_source_id(winner_fp), .ack_event(ack_event_fp), .busy(busy_fp),
      .timeout_evt(timeout_fp), .ack_valid_n_bus_o(valid_n_fp), .ack_id_bus_o(id_bus_fp)
   );

   ack_bus_arbiter_rr #(.N_SRC(4), .RR_MODE(1), .MAX_HOLD(4)) dut_to (
      .clk(clk), .rst(rst), .req(req_to), .ack_ready(ack_ready_to),
      .winner_source_id(winner_to), .ack_event(ack_event_to), .busy(busy_to),
      .timeout_evt(timeout_to), .ack_valid_n_bus_o(valid_n_to), .ack_id_bus_o(id_bus_to)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      checks++; if (ack_ready !== 4'b0000) begin errors++; $display("FAIL reset_ack_ready: got %b want 0000", ack_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (winner !== 2'd0) begin errors++; $display("FAIL reset_winner: got %0d want 0", winner); end
      checks++; if (ack_event !== 1'b0) begin errors++; $display("FAIL reset_ack_event: got %b want 0", ack_event); end
      checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_evt); end
      checks++; if (valid_n !== 1'b1 || id_bus !== 2'b11) begin errors++; $display("FAIL reset_debug_bus: got %b/%b want 1/11", valid_n, id_bus); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      req = 4'b0100;
      tick();
      checks++; if (ack_ready !== 4'b0100 || winner !== 2'd2 || ack_event !== 1'b1) begin errors++; $display("FAIL rmg_grant: got %b/%0d/%b want 0100/2/1", ack_ready, winner, ack_event); end
      rst = 1'b1;
      tick();
      checks++; if (ack_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rmg_drop: got %b/%b want 0000/0", ack_ready, busy); end
      checks++; if (winner !== 2'd0 || ack_event !== 1'b0) begin errors++; $display("FAIL rmg_winner_event: got %0d/%b want 0/0", winner, ack_event); end
      // rr_ptr restarted at 0, so src 0 beats src 3
      rst = 1'b0;
      req = 4'b1001;
      tick();
      checks++; if (ack_ready !== 4'b0001 || winner !== 2'd0 || ack_event !== 1'b1) begin errors++; $display("FAIL rmg_ptr_restart: got %b/%0d/%b want 0001/0/1", ack_ready, winner, ack_event); end
      req = 4'b0000;
      tick();
      checks++; if (ack_ready !== 4'b0000) begin errors++; $display("FAIL rmg_release: got %b want 0000", ack_ready); end
      tick();
      req = 4'b0100;
      tick();
      checks++; if (ack_ready !== 4'b0100 || winner !== 2'd2) begin errors++; $display("FAIL rmg_regrant: got %b/%0d want 0100/2", ack_ready, winner); end
      req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_single_request();
      req = 4'b0010;
      tick();
      checks++; if (ack_ready !== 4'b0010 || ack_event !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_grant: got %b/%b/%b want 0010/1/1", ack_ready, ack_event, busy); end
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++; if (busy !== 1'b1 || ack_event !== 1'b0 || ack_ready !== 4'b0010) begin errors++; $display("FAIL single_hold%0d: got %b/%b/%b want 1/0/0010", c, busy, ack_event, ack_ready); end
      end
      req = 4'b0000;
      tick();
      checks++; if (ack_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got %b/%b want 0000/0", ack_ready, busy); end
      checks++; if (winner !== 2'd1 || ack_event !== 1'b0) begin errors++; $display("FAIL single_idle_winner: got %0d/%b want 1/0", winner, ack_event); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      int n;
      rst = 1'b1;
      req = 4'b0000;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         n = 0;
         while (ack_ready === 4'b0000 && n < 4) begin
            tick();
            n++;
         end
         checks++; if (ack_ready !== exp || winner !== 2'(k % 4) || ack_event !== 1'b1) begin errors++; $display("FAIL rr_grant%0d: got %b/%0d/%b want %b/%0d/1", k, ack_ready, winner, ack_event, exp, k % 4); end
         checks++; if (n !== 1) begin errors++; $display("FAIL rr_turnaround%0d: got %0d cycles want 1", k, n); end
         tick();
         tick();
         checks++; if (ack_ready !== exp || ack_event !== 1'b0) begin errors++; $display("FAIL rr_hold%0d: got %b/%b want %b/0", k, ack_ready, ack_event, exp); end
         req[k % 4] = 1'b0;
         tick();
         checks++; if (ack_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_release%0d: got %b/%b want 0000/0", k, ack_ready, busy); end
         req[k % 4] = 1'b1;
      end
      req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_fixed_priority();
      int n;
      req_fp = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (ack_ready_fp === 4'b0000 && n < 4) begin
            tick();
            n++;
         end
         checks++; if (ack_ready_fp !== 4'b0001 || winner_fp !== 2'd0) begin errors++; $display("FAIL fp_grant%0d: got %b/%0d want 0001/0", k, ack_ready_fp, winner_fp); end
         tick();
         tick();
         req_fp[0] = 1'b0;
         tick();
         checks++; if (ack_ready_fp !== 4'b0000) begin errors++; $display("FAIL fp_release%0d: got %b want 0000", k, ack_ready_fp); end
         req_fp[0] = 1'b1;
      end
      req_fp = 4'b1010;
      tick();
      checks++; if (ack_ready_fp !== 4'b0010 || winner_fp !== 2'd1) begin errors++; $display("FAIL fp_1010: got %b/%0d want 0010/1", ack_ready_fp, winner_fp); end
      req_fp = 4'b0110;
      #1;
      checks++; if (id_bus_fp !== 2'b00 || valid_n_fp !== 1'b0) begin errors++; $display("FAIL fp_debug_0110: got %b/%b want 00/0", id_bus_fp, valid_n_fp); end
      req_fp = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_debug_bus();
      req = 4'b1100;
      #1;
      checks++; if (valid_n !== 1'b0 || id_bus !== 2'b10) begin errors++; $display("FAIL dbg_1100: got %b/%b want 0/10", valid_n, id_bus); end
      req = 4'b0101;
      #1;
      checks++; if (valid_n !== 1'b0 || id_bus !== 2'b00) begin errors++; $display("FAIL dbg_0101: got %b/%b want 0/00", valid_n, id_bus); end
      req = 4'b1000;
      #1;
      checks++; if (valid_n !== 1'b0 || id_bus !== 2'b11) begin errors++; $display("FAIL dbg_1000: got %b/%b want 0/11", valid_n, id_bus); end
      req = 4'b0000;
      #1;
      checks++; if (valid_n !== 1'b1 || id_bus !== 2'b11) begin errors++; $display("FAIL dbg_none: got %b/%b want 1/11", valid_n, id_bus); end
   endtask

   task automatic test_no_preemption();
      tick();
      req = 4'b1000;
      tick();
      checks++; if (ack_ready !== 4'b1000) begin errors++; $display("FAIL np_grant: got %b want 1000", ack_ready); end
      req = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (ack_ready !== 4'b1000 || ack_event !== 1'b0) begin errors++; $display("FAIL np_hold%0d: got %b/%b want 1000/0", c, ack_ready, ack_event); end
      end
      req = 4'b0001;
      tick();
      checks++; if (ack_ready !== 4'b0000) begin errors++; $display("FAIL np_release: got %b want 0000", ack_ready); end
      tick();
      checks++; if (ack_ready !== 4'b0001 || ack_event !== 1'b1 || winner !== 2'd0) begin errors++; $display("FAIL np_next: got %b/%b/%0d want 0001/1/0", ack_ready, ack_event, winner); end
      req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      req_to = 4'b0010;
      tick();
      checks++; if (ack_ready_to !== 4'b0010 || ack_event_to !== 1'b1) begin errors++; $display("FAIL to_grant: got %b/%b want 0010/1", ack_ready_to, ack_event_to); end
      req_to = 4'b0110;
      for (int c = 1; c < 4; c++) begin
         tick();
         checks++; if (ack_ready_to !== 4'b0010 || timeout_to !== 1'b0) begin errors++; $display("FAIL to_hold%0d: got %b/%b want 0010/0", c, ack_ready_to, timeout_to); end
      end
`ifdef ACK_ARB_TIMEOUT_EN
      tick();
      checks++; if (ack_ready_to !== 4'b0000 || timeout_to !== 1'b1 || busy_to !== 1'b0) begin errors++; $display("FAIL to_forced: got %b/%b/%b want 0000/1/0", ack_ready_to, timeout_to, busy_to); end
      tick();
      checks++; if (ack_ready_to !== 4'b0100 || winner_to !== 2'd2 || timeout_to !== 1'b0) begin errors++; $display("FAIL to_next: got %b/%0d/%b want 0100/2/0", ack_ready_to, winner_to, timeout_to); end
`else
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++; if (ack_ready_to !== 4'b0010 || timeout_to !== 1'b0) begin errors++; $display("FAIL to_kept%0d: got %b/%b want 0010/0", c, ack_ready_to, timeout_to); end
      end
`endif
      req_to = 4'b0000;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_reset_mid_grant();
      test_single_request();
      test_round_robin();
      test_fixed_priority();
      test_debug_bus();
      test_no_preemption();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
